// File: rtl/ysyx_23060171_issue_ctrl.sv
// In-order issue controller sitting beside decode.
// A scoreboard counts the GPR and CSR writes that have issued and not yet retired.
// Issue stalls on RAW hazards against that scoreboard, and it also stalls when the
// in-flight limit is reached. Serialising ops first wait for the pipeline to empty,
// then block further issue until they retire.
// Writeback has no bypass, so a hazard clears on the cycle after its retire.
module ysyx_23060171_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic [4:0]  rd,
  input  logic        rd_wen,
  input  logic        csr_ren,
  input  logic        csr_wen,
  input  logic        serial,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_rd_wen,
  input  logic        wb_csr_wen,
  output logic [3:0]  inflight,
  output logic [31:0] stall_cnt,
  output logic        err
);

  localparam logic [3:0] MaxInfl = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    SER_WAIT = 2'd2
  } stateT;

  stateT              stateReg;
  stateT              stateNext;
  logic [3:0]         inflightReg;
  logic [CNT_W-1:0]   csrPendReg;
  logic [31:0]        stallCntReg;
  logic               errReg;
  logic [CNT_W-1:0]   pendCnt [32];

  logic hazGpr;
  logic hazCsr;
  logic full;
  logic outValid;
  logic issueFire;
  logic retireOk;
  logic underflow;
  logic gprIssInc;
  logic gprRetDec;
  logic gprUnder;
  logic csrInc;
  logic csrDec;
  logic csrUnder;

  // Hazards are checked only against the registered counters.
  // A retire in the current cycle does not clear a hazard until the next cycle.
  assign hazGpr = (use_rs1 && (rs1 != 5'd0) && (pendCnt[rs1] != '0)) ||
                  (use_rs2 && (rs2 != 5'd0) && (pendCnt[rs2] != '0));
  assign hazCsr = csr_ren && (csrPendReg != '0);
  assign full   = (inflightReg == MaxInfl);

  // Issue is purely combinational. Gating with rst_n keeps the handshake quiet while reset is asserted.
  assign outValid = rst_n && in_valid && (stateReg == RUN) && !hazGpr && !hazCsr && !full &&
                    (!serial || (inflightReg == 4'd0));
  assign issueFire = outValid && out_ready;

  assign out_valid = outValid;
  assign in_ready  = issueFire;

  // Retires that arrive with nothing in flight count as underflow and change no counter.
  assign retireOk  = wb_valid && (inflightReg != 4'd0);
  assign underflow = wb_valid && (inflightReg == 4'd0);

  assign gprIssInc = issueFire && rd_wen && (rd != 5'd0);
  assign gprRetDec = retireOk && wb_rd_wen && (wb_rd != 5'd0);
  assign gprUnder  = gprRetDec && (pendCnt[wb_rd] == '0);

  assign csrInc   = issueFire && csr_wen;
  assign csrDec   = retireOk && wb_csr_wen && (csrPendReg != '0);
  assign csrUnder = retireOk && wb_csr_wen && (csrPendReg == '0);

  // One pending-write counter per GPR. x0 is hard-wired to zero because writes to it are discarded.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pendCnt[gi] = '0;
      end else begin : g_cnt
        logic [CNT_W-1:0] cntReg;
        logic             incSel;
        logic             decSel;

        assign incSel = gprIssInc && (rd == 5'(gi));
        // A retire against an empty counter is reported through err and leaves the counter at zero.
        assign decSel = gprRetDec && (wb_rd == 5'(gi)) && (cntReg != '0);

        // Issue and retire on the same register in one cycle cancel out.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cntReg <= '0;
          end else if (incSel && !decSel) begin
            cntReg <= cntReg + 1'b1;
          end else if (decSel && !incSel) begin
            cntReg <= cntReg - 1'b1;
          end
        end

        assign pendCnt[gi] = cntReg;
      end
    end
  endgenerate

  // Counter of CSR writes that are in flight. A single counter covers every CSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csrPendReg <= '0;
    end else if (csrInc && !csrDec) begin
      csrPendReg <= csrPendReg + 1'b1;
    end else if (csrDec && !csrInc) begin
      csrPendReg <= csrPendReg - 1'b1;
    end
  end

  // Count of issued but unretired instructions. Issue is blocked at the limit, so this cannot exceed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflightReg <= 4'd0;
    end else if (issueFire && !retireOk) begin
      inflightReg <= inflightReg + 4'd1;
    end else if (retireOk && !issueFire) begin
      inflightReg <= inflightReg - 4'd1;
    end
  end

  // Sticky error flag covering every kind of retire underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errReg <= 1'b0;
    end else if (underflow || gprUnder || csrUnder) begin
      errReg <= 1'b1;
    end
  end

  // Saturating stall counter.
  // A cycle counts when an instruction is held back by this block.
  // Back-pressure from EXU is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntReg <= 32'd0;
    end else if (in_valid && !outValid && (stallCntReg != 32'hFFFF_FFFF)) begin
      stallCntReg <= stallCntReg + 32'd1;
    end
  end

  // State register for the serialisation sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= RUN;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic for the serialisation sequencing.
  // A serial op that finds work in flight starts a drain.
  // Once a serial op issues, the block waits for that op to retire.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN: begin
        if (in_valid && serial && (inflightReg != 4'd0)) begin
          stateNext = DRAIN;
        end else if (issueFire && serial) begin
          stateNext = SER_WAIT;
        end
      end
      DRAIN: begin
        if (inflightReg == 4'd0) begin
          stateNext = RUN;
        end
      end
      SER_WAIT: begin
        if (retireOk && (inflightReg == 4'd1)) begin
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  assign inflight  = inflightReg;
  assign stall_cnt = stallCntReg;
  assign err       = errReg;

endmodule

// File: tb/tb_ysyx_23060171_issue_ctrl.sv
// Bench for ysyx_23060171_issue_ctrl.
// It has three parts:
// - a directed vector table;
// - a hand-written reset-mid-operation sequence;
// - a random phase checked against a queue-based model of the in-flight instructions.
module tb_ysyx_23060171_issue_ctrl;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        use_rs1;
  logic        use_rs2;
  logic [4:0]  rd;
  logic        rd_wen;
  logic        csr_ren;
  logic        csr_wen;
  logic        serial;
  logic        out_valid;
  logic        out_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_rd_wen;
  logic        wb_csr_wen;
  logic [3:0]  inflight;
  logic [31:0] stall_cnt;
  logic        err;

  always #5 clk = ~clk;

  ysyx_23060171_issue_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd(rd), .rd_wen(rd_wen), .csr_ren(csr_ren), .csr_wen(csr_wen),
    .serial(serial), .out_valid(out_valid), .out_ready(out_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen),
    .wb_csr_wen(wb_csr_wen), .inflight(inflight), .stall_cnt(stall_cnt), .err(err)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic        iv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        rw;
    logic        cr;
    logic        cw;
    logic        ser;
    logic        ordy;
    logic        wv;
    logic [4:0]  wrd;
    logic        wrw;
    logic        wcw;
    logic        eov;
    logic [3:0]  einf;
    logic [31:0] estall;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input string n, input int iv, input int r1, input int u1,
                              input int r2, input int u2, input int d, input int rw,
                              input int cr, input int cw, input int ser, input int ordy,
                              input int wv, input int wrd, input int wrw, input int wcw,
                              input int eov, input int einf, input int estall, input int eerr);
    vec_t v;
    v.name = n;   v.iv = 1'(iv);   v.rs1 = 5'(r1); v.u1 = 1'(u1);
    v.rs2 = 5'(r2); v.u2 = 1'(u2); v.rd = 5'(d);   v.rw = 1'(rw);
    v.cr = 1'(cr); v.cw = 1'(cw);  v.ser = 1'(ser); v.ordy = 1'(ordy);
    v.wv = 1'(wv); v.wrd = 5'(wrd); v.wrw = 1'(wrw); v.wcw = 1'(wcw);
    v.eov = 1'(eov); v.einf = 4'(einf); v.estall = 32'(estall); v.eerr = 1'(eerr);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = v.iv;  rs1 = v.rs1;  use_rs1 = v.u1;  rs2 = v.rs2;  use_rs2 = v.u2;
    rd = v.rd;  rd_wen = v.rw;  csr_ren = v.cr;  csr_wen = v.cw;  serial = v.ser;
    out_ready = v.ordy;  wb_valid = v.wv;  wb_rd = v.wrd;  wb_rd_wen = v.wrw;
    wb_csr_wen = v.wcw;
  endtask

  vec_t tbl[$];

  // Behavioural model:
  // - the in-flight instructions are kept as a queue;
  // - a register is pending while a queued instruction writes it;
  // - a serial op in the queue means issue is blocked until that op retires.
  typedef struct {
    int rd;
    bit rw;
    bit cw;
    bit ser;
  } ent_t;

  ent_t        mq[$];
  bit          mDrain;
  bit          mErr;
  logic [31:0] mStall;

  function automatic int pendOf(input int r);
    int c = 0;
    if (r == 0) return 0;
    foreach (mq[k]) if (mq[k].rw && mq[k].rd == r) c++;
    return c;
  endfunction

  function automatic int csrPendOf();
    int c = 0;
    foreach (mq[k]) if (mq[k].cw) c++;
    return c;
  endfunction

  function automatic bit serInQ();
    foreach (mq[k]) if (mq[k].ser) return 1'b1;
    return 1'b0;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    mq.delete();
    mDrain = 1'b0;
    mErr   = 1'b0;
    mStall = 32'd0;
  endtask

  initial begin
    vec_t idle;
    bit   expOv;
    bit   hazG;
    bit   hazC;
    ent_t e;

    rst_n = 1'b0;
    idle = mk("idle", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    drive(idle);

    //              name          iv r1 u1 r2 u2 rd rw cr cw sr ordy wv wrd wrw wcw  eov inf stall err
    tbl.push_back(mk("reset",      0, 0,0, 0,0, 0,0, 0,0,0, 0,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(mk("addi_x5",    1, 1,1, 0,0, 5,1, 0,0,0, 1,   0, 0, 0, 0,   1, 0, 0, 0));
    tbl.push_back(mk("raw_stall1", 1, 5,1, 1,1, 6,1, 0,0,0, 1,   0, 0, 0, 0,   0, 1, 0, 0));
    tbl.push_back(mk("raw_wb5",    1, 5,1, 1,1, 6,1, 0,0,0, 1,   1, 5, 1, 0,   0, 1, 1, 0));
    tbl.push_back(mk("raw_issue",  1, 5,1, 1,1, 6,1, 0,0,0, 1,   0, 0, 0, 0,   1, 0, 2, 0));
    tbl.push_back(mk("ret_x6",     0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 6, 1, 0,   0, 1, 2, 0));
    tbl.push_back(mk("wr_x0",      1, 0,0, 0,0, 0,1, 0,0,0, 1,   0, 0, 0, 0,   1, 0, 2, 0));
    tbl.push_back(mk("rd_x0",      1, 0,1, 0,1, 0,1, 0,0,0, 1,   0, 0, 0, 0,   1, 1, 2, 0));
    tbl.push_back(mk("x0_infl2",   0, 0,0, 0,0, 0,0, 0,0,0, 0,   0, 0, 0, 0,   0, 2, 2, 0));
    tbl.push_back(mk("ret_x0a",    0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 0, 1, 0,   0, 2, 2, 0));
    tbl.push_back(mk("ret_x0b",    0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 0, 1, 0,   0, 1, 2, 0));
    tbl.push_back(mk("fill0",      1, 0,0, 0,0,10,1, 0,0,0, 1,   0, 0, 0, 0,   1, 0, 2, 0));
    tbl.push_back(mk("fill1",      1, 0,0, 0,0,11,1, 0,0,0, 1,   0, 0, 0, 0,   1, 1, 2, 0));
    tbl.push_back(mk("fill2",      1, 0,0, 0,0,12,1, 0,0,0, 1,   0, 0, 0, 0,   1, 2, 2, 0));
    tbl.push_back(mk("fill3",      1, 0,0, 0,0,13,1, 0,0,0, 1,   0, 0, 0, 0,   1, 3, 2, 0));
    tbl.push_back(mk("full_stall", 1, 1,1, 0,0,20,1, 0,0,0, 1,   0, 0, 0, 0,   0, 4, 2, 0));
    tbl.push_back(mk("full_ret",   1, 1,1, 0,0,20,1, 0,0,0, 1,   1,10, 1, 0,   0, 4, 3, 0));
    tbl.push_back(mk("fifth",      1, 1,1, 0,0,20,1, 0,0,0, 1,   0, 0, 0, 0,   1, 3, 4, 0));
    tbl.push_back(mk("ret11",      0, 0,0, 0,0, 0,0, 0,0,0, 0,   1,11, 1, 0,   0, 4, 4, 0));
    tbl.push_back(mk("ret12",      0, 0,0, 0,0, 0,0, 0,0,0, 0,   1,12, 1, 0,   0, 3, 4, 0));
    tbl.push_back(mk("ser_present",1, 0,0, 0,0, 0,0, 0,0,1, 1,   0, 0, 0, 0,   0, 2, 4, 0));
    tbl.push_back(mk("drain_a",    1, 0,0, 0,0, 0,0, 0,0,1, 1,   1,13, 1, 0,   0, 2, 5, 0));
    tbl.push_back(mk("drain_b",    1, 0,0, 0,0, 0,0, 0,0,1, 1,   1,20, 1, 0,   0, 1, 6, 0));
    tbl.push_back(mk("drain_exit", 1, 0,0, 0,0, 0,0, 0,0,1, 1,   0, 0, 0, 0,   0, 0, 7, 0));
    tbl.push_back(mk("ser_issue",  1, 0,0, 0,0, 0,0, 0,0,1, 1,   0, 0, 0, 0,   1, 0, 8, 0));
    tbl.push_back(mk("ser_wait",   1, 0,0, 0,0, 3,1, 0,0,0, 1,   0, 0, 0, 0,   0, 1, 8, 0));
    tbl.push_back(mk("ser_ret",    1, 0,0, 0,0, 3,1, 0,0,0, 1,   1, 0, 0, 0,   0, 1, 9, 0));
    tbl.push_back(mk("after_ser",  1, 0,0, 0,0, 3,1, 0,0,0, 1,   0, 0, 0, 0,   1, 0,10, 0));
    tbl.push_back(mk("ret_x3",     0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 3, 1, 0,   0, 1,10, 0));
    tbl.push_back(mk("iss_x7",     1, 0,0, 0,0, 7,1, 0,0,0, 1,   0, 0, 0, 0,   1, 0,10, 0));
    tbl.push_back(mk("simul_x7",   1, 0,0, 0,0, 7,1, 0,0,0, 1,   1, 7, 1, 0,   1, 1,10, 0));
    tbl.push_back(mk("x7_pend",    1, 7,1, 0,0, 0,0, 0,0,0, 1,   0, 0, 0, 0,   0, 1,10, 0));
    tbl.push_back(mk("ret_x7",     0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 7, 1, 0,   0, 1,11, 0));
    tbl.push_back(mk("x7_free",    1, 7,1, 0,0, 0,0, 0,0,0, 1,   0, 0, 0, 0,   1, 0,11, 0));
    tbl.push_back(mk("ret_plain",  0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 0, 0, 0,   0, 1,11, 0));
    tbl.push_back(mk("csr_wr",     1, 0,0, 0,0, 0,0, 0,1,0, 1,   0, 0, 0, 0,   1, 0,11, 0));
    tbl.push_back(mk("csr_raw",    1, 0,0, 0,0, 0,0, 1,0,0, 1,   0, 0, 0, 0,   0, 1,11, 0));
    tbl.push_back(mk("csr_ret",    1, 0,0, 0,0, 0,0, 1,0,0, 1,   1, 0, 0, 1,   0, 1,12, 0));
    tbl.push_back(mk("csr_rd",     1, 0,0, 0,0, 0,0, 1,0,0, 1,   0, 0, 0, 0,   1, 0,13, 0));
    tbl.push_back(mk("ret_csr_rd", 0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 0, 0, 0,   0, 1,13, 0));
    tbl.push_back(mk("no_ordy_a",  1, 0,0, 0,0, 0,0, 0,0,0, 0,   0, 0, 0, 0,   1, 0,13, 0));
    tbl.push_back(mk("no_ordy_b",  1, 0,0, 0,0, 0,0, 0,0,0, 0,   0, 0, 0, 0,   1, 0,13, 0));
    tbl.push_back(mk("underflow",  0, 0,0, 0,0, 0,0, 0,0,0, 0,   1, 5, 1, 0,   0, 0,13, 0));
    tbl.push_back(mk("err_sticky", 0, 0,0, 0,0, 0,0, 0,0,0, 0,   0, 0, 0, 0,   0, 0,13, 1));

    #12;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: inputs are applied after the edge and outputs are sampled on the falling edge.
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("%s.out_valid", tbl[i].name), 32'(out_valid), 32'(tbl[i].eov));
      check($sformatf("%s.in_ready", tbl[i].name), 32'(in_ready), 32'(tbl[i].eov & tbl[i].ordy));
      check($sformatf("%s.inflight", tbl[i].name), 32'(inflight), 32'(tbl[i].einf));
      check($sformatf("%s.stall_cnt", tbl[i].name), stall_cnt, tbl[i].estall);
      check($sformatf("%s.err", tbl[i].name), 32'(err), 32'(tbl[i].eerr));
    end

    // Reset mid-operation:
    // - put three ops in flight;
    // - enter DRAIN with a serial op;
    // - assert reset between clock edges.
    doReset();
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      drive(mk("iss", 1, 0,0, 0,0, k,1, 0,0,0, 1, 0,0,0,0, 0,0,0,0));
    end
    @(posedge clk);
    #1;
    drive(mk("ser", 1, 0,0, 0,0, 0,0, 0,0,1, 1, 0,0,0,0, 0,0,0,0));
    @(negedge clk);
    check("rst_pre.inflight", 32'(inflight), 32'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.inflight", 32'(inflight), 32'd0);
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd0);
    check("rst_mid.stall_cnt", stall_cnt, 32'd0);
    drive(mk("rdpend", 1, 1,1, 2,1, 0,0, 0,0,0, 1, 0,0,0,0, 0,0,0,0));
    #1;
    check("rst_hold.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel.out_valid", 32'(out_valid), 32'd1);
    check("rst_rel.stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    check("rst_rel.inflight", 32'(inflight), 32'd1);
    drive(idle);

    // Random phase against the behavioural model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 8);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      use_rs1   = 1'($urandom_range(0, 1));
      use_rs2   = 1'($urandom_range(0, 1));
      rd        = 5'($urandom_range(0, 7));
      rd_wen    = ($urandom_range(0, 3) != 0);
      csr_ren   = ($urandom_range(0, 5) == 0);
      csr_wen   = ($urandom_range(0, 5) == 0);
      serial    = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0 && $urandom_range(0, 9) < 4) begin
        wb_valid   = 1'b1;
        wb_rd      = 5'(mq[0].rd);
        wb_rd_wen  = mq[0].rw;
        wb_csr_wen = mq[0].cw;
      end else begin
        wb_valid   = 1'b0;
        wb_rd      = 5'($urandom_range(0, 31));
        wb_rd_wen  = 1'($urandom_range(0, 1));
        wb_csr_wen = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      hazG  = (use_rs1 && pendOf(int'(rs1)) != 0) || (use_rs2 && pendOf(int'(rs2)) != 0);
      hazC  = csr_ren && csrPendOf() != 0;
      expOv = in_valid && !mDrain && !serInQ() && !hazG && !hazC && (mq.size() < MAXI) &&
              (!serial || mq.size() == 0);
      check($sformatf("rnd%0d.out_valid", c), 32'(out_valid), 32'(expOv));
      check($sformatf("rnd%0d.in_ready", c), 32'(in_ready), 32'(expOv && out_ready));
      check($sformatf("rnd%0d.inflight", c), 32'(inflight), 32'(mq.size()));
      check($sformatf("rnd%0d.stall_cnt", c), stall_cnt, mStall);
      check($sformatf("rnd%0d.err", c), 32'(err), 32'(mErr));
      if (mDrain) begin
        if (mq.size() == 0) mDrain = 1'b0;
      end else if (!serInQ() && in_valid && serial && mq.size() != 0) begin
        mDrain = 1'b1;
      end
      if (in_valid && !expOv && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
      if (wb_valid) begin
        if (mq.size() != 0) void'(mq.pop_front());
        else mErr = 1'b1;
      end
      if (expOv && out_ready) begin
        e.rd  = int'(rd);
        e.rw  = rd_wen;
        e.cw  = csr_wen;
        e.ser = serial;
        mq.push_back(e);
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/ysyx_23060171_issue_ctrl.md
Name: ysyx_23060171_issue_ctrl

Overview:
- In-order issue scheduler between IFU and EXU, alongside the decode stage.
- Keeps a scoreboard of GPR and CSR writes that are in flight between issue and WBU writeback.
- Stalls issue on RAW hazards and on in-flight limit; drains the pipeline before trap/serialising ops (irq/ecall/mret, fence).
- GPR/CSR writes commit at the WBU clock edge with no bypass, so hazards resolve one cycle after retire.

Parameters:
MAX_INFLIGHT, 4, max instructions issued but not retired (1..15)
CNT_W, 3, per-register pending counter width; must satisfy 2^CNT_W > MAX_INFLIGHT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction available from IFU/IDU
in_ready  out  1  instruction accepted this cycle
rs1  in  5  source register 1 index
rs2  in  5  source register 2 index
use_rs1  in  1  instruction reads rs1
use_rs2  in  1  instruction reads rs2
rd  in  5  destination GPR index
rd_wen  in  1  instruction writes rd
csr_ren  in  1  instruction reads a CSR
csr_wen  in  1  instruction writes a CSR
serial  in  1  trap/serialising op (irq, mret, fence)
out_valid  out  1  issue to EXU
out_ready  in  1  EXU can accept
wb_valid  in  1  one instruction retires at WBU this cycle
wb_rd  in  5  retiring destination
wb_rd_wen  in  1  retiring instruction wrote GPR
wb_csr_wen  in  1  retiring instruction wrote CSR
inflight  out  4  current in-flight count
stall_cnt  out  32  hazard-stall cycle counter
err  out  1  sticky retire-underflow flag

Behaviour:
- Reset: asynchronous on rst_n low.
  - Cleared to 0: all pending counters, CSR pending counter, inflight, stall_cnt and err.
  - State returns to RUN.
  - in_ready and out_valid are forced to 0 while rst_n is low.
- Hazard condition (combinational, uses registered counters only; no same-cycle retire bypass):
  - haz_gpr = (use_rs1 & rs1!=0 & pend[rs1]!=0) | (use_rs2 & rs2!=0 & pend[rs2]!=0).
  - haz_csr = csr_ren & csr_pend!=0.
  - full = (inflight == MAX_INFLIGHT).
- Issue is combinational, zero latency:
  - out_valid = in_valid & state==RUN & !haz_gpr & !haz_csr & !full & (!serial | inflight==0).
  - in_ready = out_valid & out_ready; issue fires on in_ready.
- On issue:
  - inflight+1.
  - If rd_wen & rd!=0: pend[rd]+1. rd=0 never marks pending.
  - If csr_wen: csr_pend+1.
- On wb_valid with inflight!=0:
  - inflight-1.
  - If wb_rd_wen & wb_rd!=0: pend[wb_rd]-1.
  - If wb_csr_wen: csr_pend-1.
- Simultaneous issue and retire:
  - Both updates apply; a net change of 0 leaves counters unchanged.
  - Same rd issuing and retiring together keeps pend[rd] unchanged.
- Underflow:
  - wb_valid with inflight==0 sets err (sticky until reset).
  - No counter changes; counters never wrap below 0.
  - A retire for a register whose pend is 0 also sets err; that counter stays 0.
- State machine (registered):
  - RUN → DRAIN when in_valid & serial & inflight!=0.
  - DRAIN: out_valid=0; → RUN when inflight reaches 0 (registered value).
  - RUN → SER_WAIT when a serial instruction issues.
  - SER_WAIT: out_valid=0; → RUN on the cycle wb_valid retires it (inflight goes 1→0). The next issue happens the following cycle.
- stall_cnt:
  - +1 each cycle in which in_valid & !out_valid & rst_n.
  - Saturates at 0xFFFFFFFF.
  - Cycles with out_valid=1 but out_ready=0 are not counted.
- inflight output = registered count; never exceeds MAX_INFLIGHT.

Test Plan:
- RAW stall: issue `addi x5` (rd_wen, rd=5), then present `add x6,x5,x1`. Required: out_valid=0 until the cycle after wb_valid with wb_rd=5; stall_cnt increments once per stalled cycle.
- x0 handling: issue a write to rd=0, then a read of rs1=0. Required: no stall; pend stays all-zero; inflight=1 then 2.
- Full limit, MAX_INFLIGHT=4: issue 4 independent ops with out_ready=1 and no retire. Required: inflight=4 and 5th out_valid=0. Retire 1 → 5th issues the next cycle.
- Serialise: 2 in flight, present serial=1. Required: state DRAIN, no issue until inflight=0; serial op issues; SER_WAIT blocks the next op until its wb_valid; next op issues 1 cycle later.
- Simultaneous issue and retire on rd=7 with pend[7]=1. Required: pend[7] stays 1, inflight unchanged. Separately, wb_valid at inflight=0 → err=1, inflight=0.
- Reset mid-operation: rst_n low while 3 in flight and in DRAIN. Required: immediately inflight=0, out_valid=0, state RUN; after release, a pending read of any register issues with no stall.
